// File: rtl/ip_phase_acc_pkg.sv
// Shared definitions for the phase accumulator and the downstream sin/cos generator:
// default widths, sin/cos latency and the FSM state encoding.
package ip_phase_acc_pkg;

  localparam int DEG_WD_DEF = 17;
  localparam int ACC_WD_DEF = 24;
  localparam int SC_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_STEADY = 2'd2
  } state_e;

endpackage

// File: rtl/ip_phase_acc_if.sv
// Control, configuration and angle-output bundle of the phase accumulator.
// The master (controller) pulses start/stop/tick; the slave (accumulator) returns theta and status.
interface ip_phase_acc_if
  import ip_phase_acc_pkg::*;
#(
  parameter int DEG_WD = DEG_WD_DEF,
  parameter int ACC_WD = ACC_WD_DEF
);
  logic              start;
  logic              stop;
  logic              tick;
  logic              sweep_en;
  logic [ACC_WD-1:0] fcw_init;
  logic [ACC_WD-1:0] fcw_step;
  logic [ACC_WD-1:0] fcw_end;
  logic [DEG_WD-1:0] phs_ofs;
  logic [DEG_WD-1:0] theta;
  logic              theta_vld;
  logic              sc_vld;
  logic              sweep_done;
  logic              busy;
  // Debug visibility of the FSM and the running frequency word
  state_e            state;
  logic [ACC_WD-1:0] fcw_cur;

  modport master (
    output start, stop, tick, sweep_en, fcw_init, fcw_step, fcw_end, phs_ofs,
    input  theta, theta_vld, sc_vld, sweep_done, busy, state, fcw_cur
  );

  modport slave (
    input  start, stop, tick, sweep_en, fcw_init, fcw_step, fcw_end, phs_ofs,
    output theta, theta_vld, sc_vld, sweep_done, busy, state, fcw_cur
  );

endinterface

// File: rtl/ip_vld_dly.sv
// Valid-flag delay line of DEPTH register stages (DEPTH >= 1), asynchronously cleared.
module ip_vld_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  output logic vld_late
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= vld;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign vld_late = sr_q[DEPTH-1];

endmodule

// File: rtl/ip_phase_acc.sv
// NCO phase accumulator producing theta for the sin/cos generator, in fixed-frequency
// or linear-sweep mode, plus a valid flag delay-matched to the sin/cos latency.
module ip_phase_acc
  import ip_phase_acc_pkg::*;
#(
  parameter int DEG_WD = DEG_WD_DEF,
  parameter int ACC_WD = ACC_WD_DEF,
  parameter int SC_LAT = SC_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  ip_phase_acc_if.slave  bus
);

  // Handshake: start/stop/tick are single-cycle strobes sampled on every rising edge;
  // stop overrides start, and a tick coinciding with start or stop is discarded.

  state_e            state_q;
  state_e            state_d;
  logic [ACC_WD-1:0] acc_q;
  logic [ACC_WD-1:0] fcw_cur_q;
  logic [ACC_WD-1:0] fcw_step_q;
  logic [ACC_WD-1:0] fcw_end_q;
  logic [DEG_WD-1:0] theta_q;
  logic              theta_vld_q;
  logic              sweep_done_q;
  logic              go;
  logic              adv;
  logic              crossed;
  logic              sweep_hit;
  logic signed [ACC_WD:0] nxt;
  logic signed [ACC_WD:0] end_ext;

  assign go  = bus.start & ~bus.stop;
  assign adv = bus.tick & ~bus.start & ~bus.stop & (state_q != ST_IDLE);

  // One extra bit so a signed step cannot alias an unsigned frequency word
  assign nxt     = $signed({1'b0, fcw_cur_q}) + $signed({fcw_step_q[ACC_WD-1], fcw_step_q});
  assign end_ext = $signed({1'b0, fcw_end_q});
  assign crossed = fcw_step_q[ACC_WD-1] ? (nxt <= end_ext) : (nxt >= end_ext);

  assign sweep_hit = adv & (state_q == ST_SWEEP) & crossed;

  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else if (bus.start) begin
      state_d = bus.sweep_en ? ST_SWEEP : ST_STEADY;
    end else if (sweep_hit) begin
      state_d = ST_STEADY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      fcw_cur_q    <= '0;
      fcw_step_q   <= '0;
      fcw_end_q    <= '0;
      theta_q      <= '0;
      theta_vld_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      theta_vld_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      if (go) begin
        acc_q      <= '0;
        fcw_cur_q  <= bus.fcw_init;
        fcw_step_q <= bus.fcw_step;
        fcw_end_q  <= bus.fcw_end;
      end else if (adv) begin
        theta_q     <= acc_q[ACC_WD-1 -: DEG_WD] + bus.phs_ofs;
        theta_vld_q <= 1'b1;
        acc_q       <= acc_q + fcw_cur_q;
        if (state_q == ST_SWEEP) begin
          if (crossed) begin
            fcw_cur_q    <= fcw_end_q;
            sweep_done_q <= 1'b1;
          end else begin
            fcw_cur_q <= nxt[ACC_WD-1:0];
          end
        end
      end
    end
  end

  ip_vld_dly #(
    .DEPTH (SC_LAT)
  ) u_sc_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (theta_vld_q),
    .vld_late (bus.sc_vld)
  );

  assign bus.theta      = theta_q;
  assign bus.theta_vld  = theta_vld_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.state      = state_q;
  assign bus.fcw_cur    = fcw_cur_q;

endmodule
